// File: rtl/mux_pkg.sv
// Shared definitions for the channel multiplexers: mode encoding and a
// rotating first-one search usable by any round-robin arbiter up to 32 requesters.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MAX_CH = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // Lowest-distance set bit of vec[n-1:0], walking upward from start and wrapping at n.
    function automatic pick_t rot_first_one(
        input logic [MAX_CH-1:0] vec,
        input int                n,
        input int                start
    );
        pick_t res;
        int    c;
        res = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            c = start + k;
            if (c >= n) begin
                c = c - n;
            end
            if ((k < n) && !res.found && vec[c[4:0]]) begin
                res.found = 1'b1;
                res.idx   = c[4:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_rr_n_rr_pick.sv
// Combinational round-robin picker: first valid channel strictly after ptr,
// wrapping from N_CH-1 back to channel 0.
module rr_pick
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  valid,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant_found,
    output logic [SEL_W-1:0] grant_idx
);

    logic [MAX_CH-1:0] w_vec;
    int                w_start;
    pick_t             w_pick;
    logic              w_unused;

    always_comb begin
        w_vec             = '0;
        w_vec[N_CH-1:0]   = valid;
        w_start           = (int'(ptr) >= N_CH - 1) ? 0 : int'(ptr) + 1;
        w_pick            = rot_first_one(w_vec, N_CH, w_start);
    end

    assign grant_found = w_pick.found;
    assign grant_idx   = w_pick.idx[SEL_W-1:0];
    // Upper index bits are always zero for narrower configurations.
    assign w_unused    = ^w_pick.idx;

endmodule

// File: rtl/mux_rr_n.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin grant
// feeding a single registered output stage (one word per cycle sustained).
module mux_rr_n
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int DW    = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic [N_CH-1:0]    in_valid,
    output logic [N_CH-1:0]    in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [DW-1:0]      out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic             r_out_valid;
    logic [DW-1:0]    r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_fix_found;
    logic             w_grant;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_take;
    logic [DW-1:0]    w_grant_data;

    rr_pick #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_pick (
        .valid       (in_valid),
        .ptr         (r_ptr),
        .grant_found (w_rr_found),
        .grant_idx   (w_rr_idx)
    );

    // Out-of-range indices (non-power-of-2 N_CH) must never grant.
    assign w_fix_found = (int'(sel) < N_CH) && in_valid[sel];

    always_comb begin
        w_grant     = w_fix_found;
        w_grant_idx = sel;
        if (mode == MODE_RR) begin
            w_grant     = w_rr_found;
            w_grant_idx = w_rr_idx;
        end
    end

    assign w_load_en    = !r_out_valid || out_ready;
    assign w_take       = w_grant && w_load_en && !rst;
    assign w_grant_data = in_data[int'(w_grant_idx)*DW +: DW];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
            assign in_ready[gi] = w_take && (w_grant_idx == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= SEL_W'(N_CH - 1);
        end else if (w_load_en) begin
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_ch    <= w_grant_idx;
                if (mode == MODE_RR) begin
                    r_ptr <= w_grant_idx;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_rr_n.sv
// Scoreboard bench for mux_rr_n, run concurrently on an 8-channel and a
// 5-channel instance against a grant model derived from the selection rules.
module tb_mux_rr_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit done [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
            localparam int N  = (gi == 0) ? 8 : 5;
            localparam int SW = $clog2(N);

            typedef struct {
                logic [7:0] d;
                int         ch;
            } word_t;

            logic            rst;
            logic [N*8-1:0]  in_data;
            logic [N-1:0]    in_valid;
            logic [N-1:0]    in_ready;
            logic            mode;
            logic [SW-1:0]   sel;
            logic [7:0]      out_data;
            logic [SW-1:0]   out_ch;
            logic            out_valid;
            logic            out_ready;

            mux_rr_n #(.N_CH(N), .DW(8)) dut (
                .clk       (clk),
                .rst       (rst),
                .in_data   (in_data),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .mode      (mode),
                .sel       (sel),
                .out_data  (out_data),
                .out_ch    (out_ch),
                .out_valid (out_valid),
                .out_ready (out_ready)
            );

            word_t q[$];
            int    seen[$];
            int    m_last;
            bit    pend;
            word_t pend_w;
            word_t mon_w;

            // Reference grant: fixed index, or nearest valid channel after the last RR winner.
            function automatic int model_grant();
                if (mode == 1'b0) begin
                    if (int'(sel) < N) begin
                        if (in_valid[sel]) return int'(sel);
                    end
                    return -1;
                end
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (in_valid[c]) return c;
                end
                return -1;
            endfunction

            task automatic set_ramp();
                for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
            endtask

            // Inputs are already driven; check in_ready, predict the edge, advance one cycle.
            task automatic step();
                int         g;
                bit         load;
                logic [N-1:0] exp_rdy;
                #1;
                load    = (q.size() == 0) || out_ready;
                g       = model_grant();
                exp_rdy = '0;
                if (g >= 0 && load) exp_rdy[g] = 1'b1;
                chk($sformatf("cfg%0d in_ready", gi), 64'(in_ready), 64'(exp_rdy));
                if (g >= 0 && load) begin
                    pend   = 1'b1;
                    pend_w = '{in_data[g*8 +: 8], g};
                    if (mode) m_last = g;
                end
                @(posedge clk);
                #1;
                if (pend) begin
                    q.push_back(pend_w);
                    pend = 1'b0;
                end
            endtask

            task automatic drain();
                in_valid = '0;
                out_ready = 1'b1;
                step();
                step();
            endtask

            always @(negedge clk) begin
                if (!rst) begin
                    chk($sformatf("cfg%0d out_valid", gi), 64'(out_valid), 64'(q.size() != 0));
                    if (out_valid && out_ready && q.size() != 0) begin
                        mon_w = q.pop_front();
                        chk($sformatf("cfg%0d out_data", gi), 64'(out_data), 64'(mon_w.d));
                        chk($sformatf("cfg%0d out_ch", gi), 64'(out_ch), 64'(mon_w.ch));
                        seen.push_back(int'(out_ch));
                        $display("cfg%0d word ch=%0d data=%02h", gi, out_ch, out_data);
                    end
                end
            end

            initial begin
                int   lo;
                int   hold_ch;
                logic [7:0] hold_d;
                int   exp_seq[$];

                rst = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b0;
                in_valid = '1; in_data = '0; set_ramp();
                m_last = N - 1; pend = 1'b0;
                @(posedge clk); #1;
                chk($sformatf("cfg%0d rst out_valid", gi), 64'(out_valid), 64'd0);
                chk($sformatf("cfg%0d rst out_data", gi), 64'(out_data), 64'd0);
                chk($sformatf("cfg%0d rst out_ch", gi), 64'(out_ch), 64'd0);
                chk($sformatf("cfg%0d rst in_ready", gi), 64'(in_ready), 64'd0);
                rst = 1'b0;

                // Fixed select, including indices beyond the channel count.
                out_ready = 1'b1;
                sel = SW'(5); step();
                chk($sformatf("cfg%0d fix5 valid", gi), 64'(out_valid), 64'(5 < N));
                chk($sformatf("cfg%0d fix5 data", gi), 64'(out_data), (5 < N) ? 64'h15 : 64'h00);
                sel = SW'(2); step();
                chk($sformatf("cfg%0d fix2 data", gi), 64'(out_data), 64'h12);
                chk($sformatf("cfg%0d fix2 ch", gi), 64'(out_ch), 64'd2);
                sel = SW'(5); in_valid = '1; in_valid[0] = 1'b0;
                if (5 < N) in_valid = ~(N'(1) << 5);
                step(); step();
                chk($sformatf("cfg%0d fix idle valid", gi), 64'(out_valid), 64'(5 < N && 0));
                in_valid = '1; sel = SW'(6); step(); step();
                chk($sformatf("cfg%0d fix6 valid", gi), 64'(out_valid), 64'(6 < N));
                drain();

                // Round-robin fairness with every channel requesting.
                seen.delete();
                mode = 1'b1; in_valid = '1; out_ready = 1'b1;
                repeat (10) step();
                drain();
                chk($sformatf("cfg%0d rr count", gi), 64'(seen.size() >= 10), 64'd1);
                for (int k = 0; k < 10; k++)
                    chk($sformatf("cfg%0d rr seq%0d", gi, k), 64'(seen[k]), 64'(k % N));

                // Two requesters; the higher one sits at the wrap boundary.
                seen.delete();
                lo = (N == 8) ? 2 : 0;
                in_valid = (N'(1) << lo) | (N'(1) << (N - 1));
                out_ready = 1'b1;
                repeat (4) step();
                drain();
                exp_seq = '{lo, N - 1, lo, N - 1};
                for (int k = 0; k < 4; k++)
                    chk($sformatf("cfg%0d pair seq%0d", gi, k), 64'(seen[k]), 64'(exp_seq[k]));

                // Backpressure: held word and frozen pointer, then drain-and-refill.
                in_valid = '1; out_ready = 1'b1; set_ramp();
                step();
                hold_ch = int'(out_ch); hold_d = out_data;
                chk($sformatf("cfg%0d bp first ch", gi), 64'(hold_ch), 64'd0);
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    step();
                    chk($sformatf("cfg%0d bp hold ch", gi), 64'(out_ch), 64'(hold_ch));
                    chk($sformatf("cfg%0d bp hold data", gi), 64'(out_data), 64'(hold_d));
                end
                seen.delete();
                out_ready = 1'b1;
                step();
                drain();
                chk($sformatf("cfg%0d bp drain", gi), 64'(seen[0]), 64'(hold_ch));
                chk($sformatf("cfg%0d bp refill", gi), 64'(seen[1]), 64'((hold_ch + 1) % N));

                // Mode switch keeps the round-robin pointer.
                seen.delete();
                mode = 1'b1; in_valid = N'(1) << 3; out_ready = 1'b1;
                step();
                mode = 1'b0; sel = SW'(1); in_valid = '1;
                step();
                mode = 1'b1;
                step();
                drain();
                exp_seq = '{3, 1, 4};
                for (int k = 0; k < 3; k++)
                    chk($sformatf("cfg%0d msw seq%0d", gi, k), 64'(seen[k]), 64'(exp_seq[k]));

                // Randomized traffic.
                for (int t = 0; t < 300; t++) begin
                    mode      = 1'($urandom_range(0, 1));
                    sel       = SW'($urandom_range(0, (1 << SW) - 1));
                    in_valid  = N'($urandom);
                    out_ready = ($urandom % 4) != 0;
                    for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'($urandom);
                    step();
                end

                // Reset in the middle of a held transfer.
                mode = 1'b1; in_valid = '1; out_ready = 1'b0;
                step(); step();
                #1;
                rst = 1'b1;
                #1;
                chk($sformatf("cfg%0d mid rst valid", gi), 64'(out_valid), 64'd0);
                chk($sformatf("cfg%0d mid rst data", gi), 64'(out_data), 64'd0);
                chk($sformatf("cfg%0d mid rst ch", gi), 64'(out_ch), 64'd0);
                chk($sformatf("cfg%0d mid rst rdy", gi), 64'(in_ready), 64'd0);
                q.delete(); pend = 1'b0; m_last = N - 1;
                @(posedge clk); #1;
                rst = 1'b0;
                seen.delete();
                out_ready = 1'b1;
                step();
                drain();
                chk($sformatf("cfg%0d post rst ch", gi), 64'(seen[0]), 64'd0);

                done[gi] = 1'b1;
            end
        end
    endgenerate

    initial begin
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (done[0] && done[1]) break;
        end
        if (!(done[0] && done[1])) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: done=%0d%0d, expected 11", done[0], done[1]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-channel, W-bit multiplexer with a valid/ready handshake on every input and on the output.
- Each channel is an 8-to-1-style select input. Selection is either a fixed software-driven index or round-robin among channels that are presenting data.
- One registered output stage. Sits between multiple producers and a single downstream consumer.

Parameters:
- N_CH, 8, number of input channels (2..32; need not be a power of 2).
- DW, 8, data width per channel in bits.
- SEL_W, $clog2(N_CH), width of the channel index (derived; not to be overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_CH*DW  packed channel data; channel i occupies bits [i*DW +: DW].
- in_valid  input  N_CH  channel i has data.
- in_ready  output  N_CH  channel i's data is taken this cycle (one-hot or zero).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  DW  registered selected data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset, asynchronous and immediate:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=N_CH-1, so channel 0 has first priority.
  - in_ready=0 while rst is high.
- Output register has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = !out_valid | out_ready.
- Grant g is combinational:
  - mode=0: g=sel if sel<N_CH and in_valid[sel]; otherwise no grant. sel>=N_CH never grants.
  - mode=1: g is the first index with in_valid set, searching ptr+1, ptr+2, … modulo N_CH and wrapping past N_CH-1 to 0. No grant if in_valid==0.
- in_ready[g]=load_en when a grant exists; all other in_ready bits are 0. At most one bit is set.
- Transfer on a clock edge with load_en and a grant:
  - out_data<=channel g data, out_ch<=g, out_valid<=1.
  - mode=1 only: ptr<=g. In mode=0, ptr is unchanged.
- Edge with out_valid & out_ready and no grant: out_valid<=0. out_data and out_ch hold their last values.
- Edge with !load_en: all registers hold; this is backpressure.
- Simultaneous drain and refill (FULL, out_ready=1, grant present): the register reloads in the same cycle, giving one word per cycle sustained throughput.
- Latency: input accepted at edge k appears on out_data/out_valid after edge k, i.e. one cycle.
- mode or sel changes affect only the next grant decision. Data already in the output register is unaffected. ptr is kept across mode switches.
- Fairness: in mode=1 with all channels valid and out_ready=1, grants cycle 0,1,…,N_CH-1,0,… with one grant per cycle.
- A channel's data must stay stable while in_valid is high and in_ready is low. The block does not check this.
- Reset asserted mid-transfer clears state immediately. No partial output survives.

Decomposition:
- Shared package mux_pkg holds:
  - the mode encoding constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a function for the rotating first-one search (index search from a start position with wrap), reusable by other arbiters.
- One natural sub-module, rr_pick: combinational. Inputs are the valid vector and ptr; outputs are grant_found and grant_idx.
- The top level holds the mode mux, the handshake logic and the output/pointer registers.

Test Plan:
- Reset: assert rst mid-operation with out_valid=1 -> out_valid, out_data and out_ch drop to 0 immediately; in_ready=0 while rst is high.
- Fixed mode, N_CH=8, DW=8:
  - Stimulus: channel i data = 8'h10+i, all valid, out_ready=1; step sel=5 then 2.
  - Required: in_ready=8'b0010_0000, out_data=8'h15 and out_ch=5 one cycle later, then 8'h12 and out_ch=2.
  - Also drive sel=5 with in_valid[5]=0 -> no in_ready bits set and out_valid falls to 0.
- Round-robin fairness:
  - Stimulus: mode=1, in_valid=8'hFF, out_ready=1 for 10 cycles after reset.
  - Required: out_ch sequence 0,1,2,…,7,0,1.
  - Then in_valid=8'b1000_0100 -> grants alternate 2,7,2,7.
- Backpressure:
  - Stimulus: out_ready=0 after one transfer.
  - Required: out_data and out_ch hold, in_ready=0 and ptr is frozen for 5 cycles.
  - On out_ready=1, the next RR channel after the held one is granted in the same cycle the held word drains.
- Wrap-around and non-power-of-2 (N_CH=5):
  - Stimulus: mode=1, only in_valid[4] and in_valid[0] set.
  - Required: grants 0,4,0,4.
  - mode=0 with sel=6 -> no grant ever.
- Mode switch: after an RR grant to channel 3, set mode=0 with sel=1 -> channel 1 granted. Switching back to mode=1 -> search resumes from channel 4 (ptr=3 retained).
